// File: rtl/fft_frame_buffer.sv
// -----------------------------------------------------------------------------
// fft_frame_buffer
//
// Captures the free-running DDS sample stream into an N-entry frame buffer and
// replays the frame, in index order, to the FFT core over a valid/ready stream.
// A frame is armed by a single-cycle start pulse taken only while idle. Samples
// can be decimated (one kept every decim+1 cycles). On entry, the offset-binary
// samples are converted to two's complement by inverting the MSB.
//
// Parameters
//   DATA_W   sample width, input and output
//   ADDR_W   log2 of the frame length N
//   DECIM_W  width of the decimation control
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   start      frame request, honoured only in IDLE
//   decim      decimation factor minus one, latched on an accepted start
//   din        DDS sample, offset binary, valid every cycle
//   busy       high from the cycle after an accepted start until done
//   done       one-cycle pulse after the last beat of a frame is accepted
//   out_data   two's-complement sample
//   out_index  sample index within the frame, 0..N-1
//   out_valid  out_data / out_index / out_last are valid
//   out_ready  downstream accepts the beat when out_valid && out_ready
//   out_last   high on the beat with out_index = N-1
//   state_dbg  current FSM state (IDLE=0, CAPTURE=1, DRAIN=2)
//
// Stream handshake: a beat transfers on a rising edge where out_valid and
// out_ready are both high. Once out_valid is raised it stays high, and
// out_data / out_index / out_last stay unchanged, until that transfer happens.
// out_valid does not depend combinationally on out_ready.
// -----------------------------------------------------------------------------
module fft_frame_buffer #(
   parameter int DATA_W  = 12,
   parameter int ADDR_W  = 10,
   parameter int DECIM_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [DECIM_W-1:0] decim,
   input  logic [DATA_W-1:0]  din,
   output logic               busy,
   output logic               done,
   output logic [DATA_W-1:0]  out_data,
   output logic [ADDR_W-1:0]  out_index,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic [1:0]         state_dbg
);

   localparam int N = 1 << ADDR_W;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_DRAIN   = 2'd2;

   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [1:0]         state;
   logic [DECIM_W-1:0] d_reg;
   logic [DECIM_W-1:0] phase;
   logic [ADDR_W-1:0]  waddr;
   logic [ADDR_W-1:0]  raddr;
   logic               rd_all;     // every address of the frame has been read

   // Frame storage: one write port, one registered read port.
   logic [DATA_W-1:0]  mem [N];
   logic [DATA_W-1:0]  ram_q;

   // Prefetch stage: ram_q holds a sample not yet moved to the output register.
   logic               pf_valid;
   logic [ADDR_W-1:0]  pf_index;

   // ---------------------------------------------------------------------------
   // Control strobes
   // ---------------------------------------------------------------------------
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              beat_acc;
   logic              last_acc;
   logic              load_out;
   logic              rd_en;

   // Phase 0 of every decimation period is the sample that is kept.
   assign wr_en    = (state == ST_CAPTURE) && (phase == '0);
   assign wr_data  = {~din[DATA_W-1], din[DATA_W-2:0]};

   assign beat_acc = out_valid && out_ready;
   assign last_acc = beat_acc && out_last;

   // The output register takes the prefetched sample when it is empty or its
   // current beat is leaving this cycle.
   assign load_out = pf_valid && (!out_valid || out_ready);

   // A new read is issued when the prefetch slot is empty or being emptied,
   // which keeps one beat per cycle flowing when out_ready stays high.
   assign rd_en    = (state == ST_DRAIN) && !rd_all && (!pf_valid || load_out);

   assign state_dbg = state;

   // ---------------------------------------------------------------------------
   // FSM and address counters
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         d_reg  <= '0;
         phase  <= '0;
         waddr  <= '0;
         raddr  <= '0;
         rd_all <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_CAPTURE;
                  d_reg <= decim;
                  phase <= '0;
                  waddr <= '0;
                  busy  <= 1'b1;
               end
            end

            ST_CAPTURE: begin
               phase <= (phase == d_reg) ? '0 : phase + 1'b1;
               if (wr_en) begin
                  waddr <= waddr + 1'b1;
                  if (waddr == LAST_ADDR) begin
                     state  <= ST_DRAIN;
                     raddr  <= '0;
                     rd_all <= 1'b0;
                  end
               end
            end

            ST_DRAIN: begin
               if (rd_en) begin
                  raddr <= raddr + 1'b1;
                  if (raddr == LAST_ADDR) begin
                     rd_all <= 1'b1;
                  end
               end
               if (last_acc) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Frame RAM. Contents survive reset; every frame rewrites all entries before
   // any of them is read back.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[waddr] <= wr_data;
      end
      if (rd_en) begin
         ram_q <= mem[raddr];
      end
   end

   // ---------------------------------------------------------------------------
   // Prefetch flag and output register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pf_valid  <= 1'b0;
         pf_index  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         out_index <= '0;
      end else begin
         if (rd_en) begin
            pf_valid <= 1'b1;
            pf_index <= raddr;
         end else if (load_out) begin
            pf_valid <= 1'b0;
         end

         if (load_out) begin
            out_valid <= 1'b1;
            out_data  <= ram_q;
            out_index <= pf_index;
            out_last  <= (pf_index == LAST_ADDR);
         end else if (beat_acc) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_buffer
//
// Directed bench for fft_frame_buffer. Inputs change 1 time unit after each
// rising edge; outputs are checked on the falling edge against a frame model
// that works from the sample history and the frame timing rules.
// -----------------------------------------------------------------------------
module tb_fft_frame_buffer;

   localparam int DATA_W  = 12;
   localparam int ADDR_W  = 10;
   localparam int DECIM_W = 8;
   localparam int N       = 1 << ADDR_W;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic [DECIM_W-1:0] decim = '0;
   logic [DATA_W-1:0]  din = '0;
   logic               busy;
   logic               done;
   logic [DATA_W-1:0]  out_data;
   logic [ADDR_W-1:0]  out_index;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic               out_last;
   logic [1:0]         state_dbg;

   always #5 clk = ~clk;

   fft_frame_buffer #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .DECIM_W (DECIM_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .decim     (decim),
      .din       (din),
      .busy      (busy),
      .done      (done),
      .out_data  (out_data),
      .out_index (out_index),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .state_dbg (state_dbg)
   );

   // ---------------------------------------------------------------------------
   // Counters and comparison helper
   // ---------------------------------------------------------------------------
   int n_vec = 0;
   int n_err = 0;
   int ecnt  = -1;   // index of the most recent rising edge

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, ecnt);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Frame model and scoreboard
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] hist [0:65535];  // din seen at each edge (edge index mod 2^16)
   logic [DATA_W-1:0] obs  [0:N-1];    // accepted beats of the current frame

   bit                m_active = 1'b0; // a frame has been accepted and not finished
   bit                m_done   = 1'b0;
   bit                m_all_ready = 1'b1;
   int                m_t = 0;         // edge that accepted start
   int                m_d = 0;         // decimation period minus one
   int                m_l = 0;         // edge of the last write
   int                m_acc = 0;       // beats accepted so far
   int                done_edge = 0;

   bit                p_rst = 1'b1;
   bit                p_start = 1'b0;
   bit                p_ready = 1'b0;
   bit                p_valid = 1'b0;
   logic [DECIM_W-1:0] p_decim = '0;
   logic [DATA_W-1:0]  p_data = '0;

   int                wr_edge;
   logic [15:0]       hidx;
   logic [DATA_W-1:0] exp_data;

   always @(negedge clk) begin
      ecnt = ecnt + 1;

      // Apply the events of rising edge ecnt using the inputs seen before it.
      m_done = 1'b0;
      if (p_rst) begin
         m_active = 1'b0;
      end else if (m_active) begin
         if (ecnt >= m_l + 3 && !p_ready) m_all_ready = 1'b0;
         if (p_valid && p_ready) begin
            obs[m_acc[ADDR_W-1:0]] = p_data;
            m_acc++;
            if (m_acc == N) begin
               m_active  = 1'b0;
               m_done    = 1'b1;
               done_edge = ecnt;
            end
         end
      end else if (p_start) begin
         m_active    = 1'b1;
         m_t         = ecnt;
         m_d         = int'(p_decim);
         m_acc       = 0;
         m_all_ready = 1'b1;
         m_l         = m_t + 1 + (N - 1) * (m_d + 1);
      end

      hidx = 16'(ecnt + 1);
      hist[hidx] = din;

      // Compare DUT outputs after edge ecnt.
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_done));
      if (!m_active || ecnt < m_l + 2)
         chk("valid_low", 32'(out_valid), 32'd0);
      else if (ecnt == m_l + 2 || (p_valid && !p_ready) || m_all_ready)
         chk("valid_high", 32'(out_valid), 32'd1);

      if (m_active && out_valid) begin
         wr_edge  = m_t + 1 + m_acc * (m_d + 1);
         hidx     = 16'(wr_edge);
         exp_data = hist[hidx] ^ 12'h800;
         chk("data", 32'(out_data), 32'(exp_data));
         chk("index", 32'(out_index), 32'(m_acc));
         chk("last", 32'(out_last), 32'(m_acc == N - 1));
      end

      p_rst   = rst;
      p_start = start;
      p_decim = decim;
      p_ready = out_ready;
      p_valid = out_valid;
      p_data  = out_data;
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   bit bp_en = 1'b0;

   // Advance one cycle; din ramps by one each edge.
   task automatic tick();
      @(posedge clk);
      #1;
      din = din + 12'd1;
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
   endtask

   // Request a frame; din presented at the first capture edge is first_din.
   task automatic start_frame(input int d, input logic [DATA_W-1:0] first_din);
      decim = DECIM_W'(d);
      start = 1'b1;
      din   = first_din - 12'd1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_start(input int d);
      decim = DECIM_W'(d);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         if (done) seen = 1'b1;
      end
      chk("done_seen", 32'(seen), 32'd1);
   endtask

   task automatic wait_beat(input int idx, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         if (out_valid && int'(out_index) == idx) seen = 1'b1;
      end
      chk("beat_seen", 32'(seen), 32'd1);
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      // Reset held 3 cycles with start and out_ready high.
      rst = 1'b1; start = 1'b1; out_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0; start = 1'b0;
      tick();
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_index", 32'(out_index), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_state", 32'(state_dbg), 32'd0);

      // Ramp, decim = 0, out_ready = 1.
      start_frame(0, 12'h000);
      wait_done(3000);
      tick();
      chk("ramp_k0", 32'(obs[0]), 32'h800);
      chk("ramp_k1", 32'(obs[1]), 32'h801);
      chk("ramp_k1023", 32'(obs[1023]), 32'hBFF);
      chk("ramp_period", 32'(done_edge - m_t), 32'd2050);

      // Decimation by 4; decim changed after start must not matter.
      start_frame(3, 12'h000);
      decim = 8'd7;
      wait_done(6000);
      tick();
      chk("dec_k1", 32'(obs[1]), 32'h804);
      chk("dec_k1023", 32'(obs[1023]), 32'h7FC);
      chk("dec_period", 32'(done_edge - m_t), 32'd5119);

      // Random backpressure.
      bp_en = 1'b1;
      start_frame(0, 12'h123);
      wait_done(6000);
      bp_en = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_k0", 32'(obs[0]), 32'h923);
      chk("bp_k512", 32'(obs[512]), 32'hB23);
      chk("bp_k1023", 32'(obs[1023]), 32'hD22);

      // Start pulses during CAPTURE and DRAIN are ignored; start in the done
      // cycle begins a new frame.
      start_frame(1, 12'h7FF);
      repeat (100) tick();
      pulse_start(5);
      wait_beat(0, 3000);
      pulse_start(6);
      wait_done(3000);
      chk("busy_k0", 32'(obs[0]), 32'hFFF);
      chk("busy_k1", 32'(obs[1]), 32'h001);
      start_frame(0, 12'h200);
      chk("busy_restart", 32'(busy), 32'd1);
      wait_done(3000);
      tick();
      chk("restart_k1023", 32'(obs[1023]), 32'hDFF);

      // Reset while beat 500 is pending.
      start_frame(0, 12'h400);
      wait_beat(500, 3000);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      repeat (5) tick();
      start_frame(2, 12'h055);
      wait_done(5000);
      tick();
      chk("post_rst_k0", 32'(obs[0]), 32'h855);
      chk("post_rst_k1023", 32'(obs[1023]), 32'h452);
      chk("post_rst_period", 32'(done_edge - m_t), 32'd4096);

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
